// File: rtl/lockin_decimator_if.sv
// Bus bundle for the lock-in decimator: sample input strobe, block-size
// request, consumer handshake, and the decimated result registers.
// The slave modport is the decimator; the master modport is whoever
// drives samples and reads results.
interface lockin_decimator_if #(
    parameter int DATA_W = 24,
    parameter int SEQ_W  = 8
);
    logic                      tick_i;
    logic signed [DATA_W-1:0]  x_i;
    logic signed [DATA_W-1:0]  y_i;
    logic [3:0]                log2n_i;
    logic                      ack_i;
    logic                      clr_ovr_i;

    logic signed [DATA_W-1:0]  x_o;
    logic signed [DATA_W-1:0]  y_o;
    logic                      tick_o;
    logic [SEQ_W-1:0]          seq_o;
    logic                      valid_o;
    logic                      overrun_o;
    logic [DATA_W+SEQ_W-1:0]   oreg1_o;
    logic [DATA_W+SEQ_W-1:0]   oreg2_o;

    modport master (
        output tick_i, x_i, y_i, log2n_i, ack_i, clr_ovr_i,
        input  x_o, y_o, tick_o, seq_o, valid_o, overrun_o, oreg1_o, oreg2_o
    );

    modport slave (
        input  tick_i, x_i, y_i, log2n_i, ack_i, clr_ovr_i,
        output x_o, y_o, tick_o, seq_o, valid_o, overrun_o, oreg1_o, oreg2_o
    );
endinterface

// File: rtl/lockin_decimator.sv
// Lock-in result decimator: boxcar-averages 2^k consecutive (x, y) pairs
// and publishes one averaged pair per block with a wrapping sequence tag,
// a valid/ack handshake and a sticky overrun flag.
// Optional build macro LOCKIN_DECIM_ROUND_EN: round half toward +inf
// before the divide-by-shift and saturate to the output width. Without it
// the average is a plain arithmetic shift (floor).
module lockin_decimator #(
    parameter int DATA_W     = 24,
    parameter int LOG2_N_MAX = 8,
    parameter int SEQ_W      = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    lockin_decimator_if.slave bus
);
    // Accumulators are wide enough for 2^LOG2_N_MAX full-scale samples.
    localparam int         ACC_W = DATA_W + LOG2_N_MAX;
    localparam int         CNT_W = LOG2_N_MAX + 1;
    localparam logic [3:0] K_MAX = 4'(LOG2_N_MAX);

    typedef enum logic [1:0] {
        START = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                   state, state_nxt;

    logic signed [ACC_W-1:0]  acc_x_p0, acc_y_p0;
    logic signed [ACC_W-1:0]  acc_x_nxt, acc_y_nxt;
    logic signed [ACC_W-1:0]  smp_x, smp_y;
    logic [CNT_W-1:0]         cnt_p0, cnt_nxt, blk_len;
    logic [3:0]               k_p0, k_req, k_eff;
    logic                     take_first, take_add, emit_go, tick_out;

    logic signed [DATA_W-1:0] x_p1, y_p1;
    logic [SEQ_W-1:0]         seq_p1;
    logic                     vld_p1, ovr_p1;

`ifdef LOCKIN_DECIM_ROUND_EN
    localparam logic signed [ACC_W:0] SAT_HI =
        {{(LOG2_N_MAX + 1){1'b0}}, 1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO =
        {{(LOG2_N_MAX + 1){1'b1}}, 1'b1, {(DATA_W - 1){1'b0}}};

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W:0] v);
        if (v > SAT_HI)
            return SAT_HI[DATA_W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[DATA_W-1:0];
        else
            return v[DATA_W-1:0];
    endfunction

    // One guard bit above the accumulator absorbs the rounding constant.
    function automatic logic signed [DATA_W-1:0] scale(
        input logic signed [ACC_W-1:0] acc,
        input logic [3:0]              k
    );
        logic signed [ACC_W:0] wide;
        wide = {acc[ACC_W-1], acc};
        if (k != 4'd0)
            wide = wide + ((ACC_W + 1)'(1) <<< (k - 4'd1));
        wide = wide >>> k;
        return sat(wide);
    endfunction
`else
    // The mean of in-range samples is always in range, so a plain
    // truncation after the shift is exact.
    function automatic logic signed [DATA_W-1:0] scale(
        input logic signed [ACC_W-1:0] acc,
        input logic [3:0]              k
    );
        return DATA_W'(acc >>> k);
    endfunction
`endif

    // Sample sign extension, effective block size and accumulate arithmetic.
    always_comb begin
        k_req     = (bus.log2n_i > K_MAX) ? K_MAX : bus.log2n_i;
        k_eff     = take_first ? k_req : k_p0;
        smp_x     = {{LOG2_N_MAX{bus.x_i[DATA_W-1]}}, bus.x_i};
        smp_y     = {{LOG2_N_MAX{bus.y_i[DATA_W-1]}}, bus.y_i};
        acc_x_nxt = take_first ? smp_x : acc_x_p0 + smp_x;
        acc_y_nxt = take_first ? smp_y : acc_y_p0 + smp_y;
        cnt_nxt   = take_first ? CNT_W'(1) : cnt_p0 + CNT_W'(1);
        blk_len   = CNT_W'(1) << k_eff;
        emit_go   = (take_first | take_add) && (cnt_nxt == blk_len);
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            state <= START;
        else
            state <= state_nxt;
    end

    // FSM next state: a tick in EMIT opens the next block without a gap.
    always_comb begin
        state_nxt = state;
        case (state)
            START: begin
                if (bus.tick_i)
                    state_nxt = emit_go ? EMIT : ACCUM;
            end
            ACCUM: begin
                if (bus.tick_i && emit_go)
                    state_nxt = EMIT;
            end
            EMIT: begin
                if (bus.tick_i)
                    state_nxt = emit_go ? EMIT : ACCUM;
                else
                    state_nxt = START;
            end
            default: state_nxt = START;
        endcase
    end

    // FSM outputs: which accumulate action this tick takes, and the strobe.
    always_comb begin
        take_first = bus.tick_i && ((state == START) || (state == EMIT));
        take_add   = bus.tick_i && (state == ACCUM);
        tick_out   = (state == EMIT);
    end

    // ---- stage p0: block accumulators and sample count ----
    // Load on the first sample of a block, add on the rest.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_x_p0 <= '0;
            acc_y_p0 <= '0;
            cnt_p0   <= '0;
            k_p0     <= '0;
        end else if (take_first | take_add) begin
            acc_x_p0 <= acc_x_nxt;
            acc_y_p0 <= acc_y_nxt;
            cnt_p0   <= cnt_nxt;
            if (take_first)
                k_p0 <= k_req;
        end
    end

    // ---- stage p1: published result, sequence tag and handshake ----
    // The final sample's sum is scaled straight from the adder so the
    // result lands one cycle after the closing tick.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_p1   <= '0;
            y_p1   <= '0;
            seq_p1 <= '0;
            vld_p1 <= 1'b0;
            ovr_p1 <= 1'b0;
        end else begin
            if (emit_go) begin
                x_p1   <= scale(acc_x_nxt, k_eff);
                y_p1   <= scale(acc_y_nxt, k_eff);
                seq_p1 <= seq_p1 + SEQ_W'(1);
            end
            if (emit_go)
                vld_p1 <= 1'b1;
            else if (bus.ack_i)
                vld_p1 <= 1'b0;
            if (emit_go && vld_p1 && !bus.ack_i)
                ovr_p1 <= 1'b1;
            else if (bus.clr_ovr_i)
                ovr_p1 <= 1'b0;
        end
    end

    assign bus.x_o       = x_p1;
    assign bus.y_o       = y_p1;
    assign bus.seq_o     = seq_p1;
    assign bus.tick_o    = tick_out;
    assign bus.valid_o   = vld_p1;
    assign bus.overrun_o = ovr_p1;
    assign bus.oreg1_o   = {seq_p1, x_p1};
    assign bus.oreg2_o   = {seq_p1, y_p1};
endmodule

// File: tb/tb_lockin_decimator.sv
// Scoreboard bench for lockin_decimator: the stimulus side pushes the
// hand-computed result of each closing tick; a negedge monitor pops and
// compares whenever tick_o is seen.
module tb_lockin_decimator;
    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        logic signed [23:0] x;
        logic signed [23:0] y;
        logic [7:0]         seq;
        int                 due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_seq = 8'd0;

    lockin_decimator_if #(.DATA_W(24), .SEQ_W(8)) bus ();

    lockin_decimator #(.DATA_W(24), .LOG2_N_MAX(8), .SEQ_W(8)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every tick_o must match the oldest expected result, on time.
    always @(negedge clk_i) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            exp_t m;
            m = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_tick: no tick_o at cycle %0d for seq %0d", m.due, m.seq);
        end
        if (bus.tick_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_tick: tick_o at cycle %0d, x_o=%0d", cyc, bus.x_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tick_time", 32'(cyc), 32'(e.due));
                chk("x_o", 32'(bus.x_o), 32'(e.x));
                chk("y_o", 32'(bus.y_o), 32'(e.y));
                chk("seq_o", 32'(bus.seq_o), 32'(e.seq));
                chk("oreg1_o", bus.oreg1_o, {e.seq, e.x});
                chk("oreg2_o", bus.oreg2_o, {e.seq, e.y});
            end
        end
    end

    // Drive one sample for one cycle; when it closes a block, queue the result.
    task automatic tick(input logic signed [23:0] x, input logic signed [23:0] y,
                        input bit last, input logic signed [23:0] ex,
                        input logic signed [23:0] ey);
        bus.tick_i = 1'b1;
        bus.x_i    = x;
        bus.y_i    = y;
        @(posedge clk_i);
        #1;
        bus.tick_i = 1'b0;
        if (last) begin
            exp_seq = exp_seq + 8'd1;
            sb.push_back('{ex, ey, exp_seq, cyc});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle(1);
        reset_i = 1'b0;
        exp_seq = 8'd0;
    endtask

    task automatic pulse_ack();
        bus.ack_i = 1'b1;
        idle(1);
        bus.ack_i = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_ovr_i = 1'b1;
        idle(1);
        bus.clr_ovr_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [23:0] ex1;
        logic signed [23:0] ey1;
        bus.tick_i    = 1'b0;
        bus.x_i       = '0;
        bus.y_i       = '0;
        bus.log2n_i   = 4'd0;
        bus.ack_i     = 1'b0;
        bus.clr_ovr_i = 1'b0;

        // Reset state
        reset_i = 1'b1;
        idle(3);
        reset_i = 1'b0;
        exp_seq = 8'd0;
        chk("rst_x_o", 32'(bus.x_o), 32'd0);
        chk("rst_y_o", 32'(bus.y_o), 32'd0);
        chk("rst_seq_o", 32'(bus.seq_o), 32'd0);
        chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
        chk("rst_overrun_o", 32'(bus.overrun_o), 32'd0);
        chk("rst_tick_o", 32'(bus.tick_o), 32'd0);
        chk("rst_oreg1_o", bus.oreg1_o, 32'd0);

        // k=2 basic average
        bus.log2n_i = 4'd2;
        tick(24'sd4,  -24'sd4,  1'b0, 24'sd0, 24'sd0);
        tick(24'sd8,  -24'sd8,  1'b0, 24'sd0, 24'sd0);
        tick(24'sd12, -24'sd12, 1'b0, 24'sd0, 24'sd0);
        tick(24'sd16, -24'sd16, 1'b1, 24'sd10, -24'sd10);
        chk("basic_oreg1", bus.oreg1_o, 32'h0100000A);
        chk("basic_valid", 32'(bus.valid_o), 32'd1);
        idle(1);
        chk("basic_tick_single", 32'(bus.tick_o), 32'd0);
        pulse_ack();
        chk("ack_clears_valid", 32'(bus.valid_o), 32'd0);

        // k=1 rounding behaviour on a half-way negative and positive mean
`ifdef LOCKIN_DECIM_ROUND_EN
        ex1 = -24'sd1;
        ey1 = 24'sd4;
`else
        ex1 = -24'sd2;
        ey1 = 24'sd3;
`endif
        bus.log2n_i = 4'd1;
        tick(-24'sd1, 24'sd3, 1'b0, 24'sd0, 24'sd0);
        tick(-24'sd2, 24'sd4, 1'b1, ex1, ey1);
        idle(2);

        // Full-scale blocks at k=8; second block requests 15 (clamped to 8)
        bus.log2n_i = 4'd8;
        for (int i = 0; i < 256; i++)
            tick(24'sh7FFFFF, 24'sh800000, i == 255, 24'sh7FFFFF, 24'sh800000);
        idle(2);
        bus.log2n_i = 4'd15;
        for (int i = 0; i < 256; i++)
            tick(24'sh800000, 24'sh7FFFFF, i == 255, 24'sh800000, 24'sh7FFFFF);
        idle(2);

        // k=0 pass-through, back-to-back ticks, sequence wrap
        do_reset();
        bus.log2n_i = 4'd0;
        for (int i = 0; i < 257; i++)
            tick(24'(i), ~24'(i), 1'b1, 24'(i), ~24'(i));
        chk("wrap_seq", 32'(bus.seq_o), 32'd1);
        idle(2);

        // Handshake and overrun
        do_reset();
        bus.log2n_i = 4'd0;
        tick(24'sd5, 24'sd6, 1'b1, 24'sd5, 24'sd6);
        chk("first_emit_no_ovr", 32'(bus.overrun_o), 32'd0);
        tick(24'sd7, 24'sd8, 1'b1, 24'sd7, 24'sd8);
        chk("ovr_set", 32'(bus.overrun_o), 32'd1);
        chk("ovr_valid", 32'(bus.valid_o), 32'd1);
        chk("ovr_seq", 32'(bus.seq_o), 32'd2);
        pulse_ack();
        chk("ack_valid_low", 32'(bus.valid_o), 32'd0);
        chk("ack_ovr_sticky", 32'(bus.overrun_o), 32'd1);
        pulse_ack();
        chk("ack_idle_valid", 32'(bus.valid_o), 32'd0);
        pulse_clr();
        chk("clr_ovr", 32'(bus.overrun_o), 32'd0);
        tick(24'sd9, 24'sd10, 1'b1, 24'sd9, 24'sd10);
        bus.ack_i = 1'b1;
        tick(24'sd11, 24'sd12, 1'b1, 24'sd11, 24'sd12);
        bus.ack_i = 1'b0;
        chk("ack_emit_valid", 32'(bus.valid_o), 32'd1);
        chk("ack_emit_no_ovr", 32'(bus.overrun_o), 32'd0);
        bus.clr_ovr_i = 1'b1;
        tick(24'sd13, 24'sd14, 1'b1, 24'sd13, 24'sd14);
        bus.clr_ovr_i = 1'b0;
        chk("clr_vs_set_wins", 32'(bus.overrun_o), 32'd1);
        idle(2);

        // Reset discards a partial block
        do_reset();
        bus.log2n_i = 4'd2;
        tick(24'sd1000, 24'sd1000, 1'b0, 24'sd0, 24'sd0);
        tick(24'sd1000, 24'sd1000, 1'b0, 24'sd0, 24'sd0);
        do_reset();
        tick(24'sd100, 24'sd0, 1'b0, 24'sd0, 24'sd0);
        tick(24'sd100, 24'sd0, 1'b0, 24'sd0, 24'sd0);
        tick(24'sd100, 24'sd0, 1'b0, 24'sd0, 24'sd0);
        tick(24'sd100, 24'sd0, 1'b1, 24'sd100, 24'sd0);
        chk("rst_block_x", 32'(bus.x_o), 32'd100);
        chk("rst_block_seq", 32'(bus.seq_o), 32'd1);
        idle(2);

        // Block size changed mid-block applies only to the next block
        bus.log2n_i = 4'd2;
        tick(24'sd4, -24'sd4, 1'b0, 24'sd0, 24'sd0);
        bus.log2n_i = 4'd3;
        tick(24'sd4, -24'sd4, 1'b0, 24'sd0, 24'sd0);
        tick(24'sd4, -24'sd4, 1'b0, 24'sd0, 24'sd0);
        tick(24'sd4, -24'sd4, 1'b1, 24'sd4, -24'sd4);
        for (int i = 0; i < 8; i++)
            tick((i % 2 == 0) ? 24'sd16 : 24'sd0, 24'(2 * i), i == 7, 24'sd8, 24'sd7);

        // Let the scoreboard drain, bounded
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            idle(1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
